switch_check_scheduler: RTL
===========================

// Module: switch_check_scheduler
// PURPOSE
//   Clocked controller for the switch "exactly-k-of-n" check datapath. It does three things:
//   - debounces and synchronises the 8 board switches;
//   - time-shares ONE 4-bit popcount/compare unit between the low nibble (target 2) and the high nibble (target 1);
//   - drives registered LED results.
//   Sits between the board switch pins and the LED pins, in the top-level board wrapper.
// PARAMETERS
//   DEBOUNCE_CYCLES  1000000  consecutive stable cycles before a switch vector is accepted (10 ms @100 MHz); min 2
//   CNT_W            20       debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
//   TARGET_LO        2        required popcount of sw[3:0] for led[0]
//   TARGET_HI        1        required popcount of sw[7:4] for led[1]
// PORTS
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   sw        in   8  raw asynchronous switch inputs
//   led       out  2  led[0]=popcnt(sw[3:0])==TARGET_LO, led[1]=popcnt(sw[7:4])==TARGET_HI (registered)
//   busy      out  1  high while an evaluation is in flight (EVAL_LO/EVAL_HI/COMMIT)
//   eval_cnt  out  8  completed evaluations; wraps 255->0
// BEHAVIOUR
//   Reset values (async on rst_n low):
//   - led=0, busy=0, eval_cnt=0, state=IDLE.
//   - sync flops=0, sw_prev=0, sw_db=0, pending=0, snap=0, debounce counter=0.
//   Synchroniser: 2-flop on all 8 bits -> sw_sync; sw_prev = sw_sync delayed one cycle.
//   Debounce (whole vector):
//   - Counter clears if sw_sync!=sw_prev or sw_sync==sw_db; otherwise it increments.
//   - When counter==DEBOUNCE_CYCLES-1 and the increment condition holds: sw_db<=sw_sync, counter<=0, pending<=1.
//   - Any glitch shorter than DEBOUNCE_CYCLES stable cycles never reaches sw_db.
//   FSM (IDLE, EVAL_LO, EVAL_HI, COMMIT), one shared popcount unit, mux-selected by state:
//   - IDLE: if pending -> snap<=sw_db, pending<=0, go EVAL_LO. Else stay.
//   - EVAL_LO: unit input=snap[3:0]; res_lo<=(pop==TARGET_LO); go EVAL_HI.
//   - EVAL_HI: unit input=snap[7:4]; res_hi<=(pop==TARGET_HI); go COMMIT.
//   - COMMIT: led<={res_hi,res_lo}; eval_cnt<=eval_cnt+1 (mod 256); go IDLE.
//   - busy = (state!=IDLE), registered with state.
//   Latency, with sw_db updated at edge E:
//   - E+1 enter EVAL_LO, snap loaded.
//   - E+2 enter EVAL_HI.
//   - E+3 enter COMMIT.
//   - E+4 led/eval_cnt updated, back in IDLE.
//   - busy is high exactly 3 cycles.
//   Widths: popcount is 3 bits (0..4); compare is unsigned against the 3-bit target.
//   Boundary rules:
//   - New sw_db while busy: pending set, snap unchanged; the in-flight result commits from the old snap.
//     The next evaluation starts at the edge after COMMIT (IDLE sees pending).
//   - Multiple sw_db changes while busy collapse into one pending; the latest sw_db is evaluated.
//   - pending set and IDLE consume in the same cycle: the set wins (pending stays 1), so no change is lost.
//   - Reset mid-evaluation: aborts immediately, led=0, no commit.
//     After release, nonzero switches re-debounce and re-evaluate.
// TESTING (sim with DEBOUNCE_CYCLES=4, CNT_W=3)
//   1 rst_n low, sw=8'hFF -> led=00, busy=0, eval_cnt=0; hold 10 cycles, no change.
//   2 sw=8'b0001_0011 held 12 cycles -> led=2'b11 at E+4, eval_cnt=1, busy high exactly 3 cycles.
//   3 From settled 8'h00: pulse sw=8'h0F for 2 cycles then back -> sw_db stays 0, eval_cnt unchanged.
//   4 Sweep sw 0..255, each held 12 cycles -> led[0]==($countones(sw[3:0])==2), led[1]==($countones(sw[7:4])==1).
//     eval_cnt reaches 255 (8'h00 is not a change); step 0 again -> eval_cnt wraps to 0.
//   5 sw 8'h03 then 8'h10, so the second sw_db update lands at E+2 ->
//     led=01 at E+4, then led=10 at E+8, eval_cnt +2.
//   6 rst_n pulsed low while state=EVAL_HI (sw=8'h03) -> led=00, eval_cnt=0 immediately.
//     After release -> led=01 after re-debounce +4 cycles.

Source files
------------

// File: rtl/switch_check_scheduler.sv
// Board-switch front end: synchronises and debounces the 8 switches, then checks both
// nibbles against their target popcounts using one shared popcount/compare unit.
module switch_check_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int TARGET_LO       = 2,
    parameter int TARGET_HI       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    output logic [1:0] led,
    output logic       busy,
    output logic [7:0] eval_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL_LO = 2'd1,
        EVAL_HI = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       TGT_LO   = 3'(TARGET_LO);
    localparam logic [2:0]       TGT_HI   = 3'(TARGET_HI);

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       sync_meta;
    logic [7:0]       sw_sync;
    logic [7:0]       sw_prev;
    logic [7:0]       sw_db;
    logic [CNT_W-1:0] db_cnt;
    logic             db_inc;
    logic             db_load;

    logic             pending;
    logic [7:0]       snap;
    logic             res_lo;
    logic             res_hi;

    logic             load_snap;
    logic             capture_lo;
    logic             capture_hi;
    logic             commit;
    logic             sel_hi;

    logic [3:0]       unit_in;
    logic [2:0]       unit_tgt;
    logic [2:0]       unit_pop;
    logic             unit_match;

    // Two-flop synchroniser plus one delay stage used for stability detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sw_sync   <= '0;
            sw_prev   <= '0;
        end else begin
            sync_meta <= sw;
            sw_sync   <= sync_meta;
            sw_prev   <= sw_sync;
        end
    end

    // The counter only runs while a stable vector differs from the accepted one.
    assign db_inc  = (sw_sync == sw_prev) && (sw_sync != sw_db);
    assign db_load = db_inc && (db_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            sw_db  <= '0;
        end else if (!db_inc) begin
            db_cnt <= '0;
        end else if (db_load) begin
            db_cnt <= '0;
            sw_db  <= sw_sync;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // pending is the request flag: the debouncer raises it on every accepted vector
    // and IDLE consumes it by loading snap; a raise in the consume cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (db_load) begin
            pending <= 1'b1;
        end else if (load_snap) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending) state_nxt = EVAL_LO;
            EVAL_LO: state_nxt = EVAL_HI;
            EVAL_HI: state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_snap  = 1'b0;
        capture_lo = 1'b0;
        capture_hi = 1'b0;
        commit     = 1'b0;
        sel_hi     = 1'b0;
        case (state)
            IDLE:    load_snap = pending;
            EVAL_LO: capture_lo = 1'b1;
            EVAL_HI: begin
                capture_hi = 1'b1;
                sel_hi     = 1'b1;
            end
            COMMIT:  commit = 1'b1;
            default: ;
        endcase
    end

    // Shared popcount/compare unit; the state picks the nibble and its target.
    assign unit_in    = sel_hi ? snap[7:4] : snap[3:0];
    assign unit_tgt   = sel_hi ? TGT_HI : TGT_LO;
    assign unit_pop   = 3'(unit_in[0]) + 3'(unit_in[1]) + 3'(unit_in[2]) + 3'(unit_in[3]);
    assign unit_match = (unit_pop == unit_tgt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap     <= '0;
            res_lo   <= 1'b0;
            res_hi   <= 1'b0;
            led      <= '0;
            eval_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            if (load_snap) begin
                snap <= sw_db;
            end
            if (capture_lo) begin
                res_lo <= unit_match;
            end
            if (capture_hi) begin
                res_hi <= unit_match;
            end
            if (commit) begin
                led      <= {res_hi, res_lo};
                eval_cnt <= eval_cnt + 8'd1;
            end
            busy <= (state_nxt != IDLE);
        end
    end

endmodule
